// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution MAC sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int WINDOW_CNT_W  = 16;

    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_NUM_TERMS  = 72;
    localparam int DEF_PIPE_LAT   = 8;

    localparam int TERM_CNT_W = $clog2(DEF_NUM_TERMS);
    localparam int LAT_CNT_W  = $clog2(DEF_PIPE_LAT + 1);

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int cnt_width(input int range);
        return (range < 2) ? 1 : $clog2(range);
    endfunction

endpackage

// File: rtl/term_window_sreg.sv
// Word-wide shift register holding one window of terms; new words enter at
// the top and older words move toward word 0.
module term_window_sreg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 72
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         din,
    output logic [DEPTH*WIDTH-1:0]   window
);

    // Shift one word toward word 0 on each enable, inserting din at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
        end else if (en) begin
            window <= {din, window[DEPTH*WIDTH-1:WIDTH]};
        end
    end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Frames (activation, weight) pairs into full convolution windows, holds the
// term buses while the multiply/tree-add pipeline drains, then presents the
// captured sum on a back-pressured result port.
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int NUM_TERMS  = DEF_NUM_TERMS,
    parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    input  logic [WORD_WIDTH-1:0]           i_a,
    input  logic [WORD_WIDTH-1:0]           i_b,
    output logic                            o_ready,
    input  logic                            i_abort,
    output logic [NUM_TERMS*WORD_WIDTH-1:0] o_terms_a,
    output logic [NUM_TERMS*WORD_WIDTH-1:0] o_terms_b,
    input  logic [WORD_WIDTH-1:0]           i_sum,
    output logic [WORD_WIDTH-1:0]           o_result,
    output logic                            o_result_valid,
    input  logic                            i_result_ready,
    output logic                            o_busy,
    output logic [WINDOW_CNT_W-1:0]         o_window_count
);

    localparam int CNT_W = cnt_width(NUM_TERMS);
    localparam int LAT_W = cnt_width(PIPE_LAT + 1);

    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_TERMS - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(PIPE_LAT - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  term_count;
    logic [LAT_W-1:0]  lat_count;

    logic              shift_en;
    logic              last_accept;
    logic              capture;
    logic              handshake;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; a flush overrides every other transition.
    always_comb begin
        next_state = state;
        if (i_abort) begin
            next_state = COLLECT;
        end else begin
            case (state)
                COLLECT: if (last_accept) next_state = DRAIN;
                DRAIN:   if (capture)     next_state = HOLD;
                HOLD:    if (handshake)   next_state = COLLECT;
                default:                  next_state = COLLECT;
            endcase
        end
    end

    // Output decode: ready/busy and the qualified strobes used by the counters.
    always_comb begin
        o_ready     = (state == COLLECT);
        o_busy      = (state != COLLECT);
        shift_en    = (state == COLLECT) && i_valid && !i_abort;
        last_accept = shift_en && (term_count == LAST_TERM);
        capture     = (state == DRAIN) && (lat_count == '0) && !i_abort;
        handshake   = (state == HOLD) && o_result_valid && i_result_ready && !i_abort;
    end

    // Term count and pipeline latency counters; flush clears both.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            term_count <= '0;
            lat_count  <= '0;
        end else if (i_abort) begin
            term_count <= '0;
            lat_count  <= '0;
        end else if (last_accept) begin
            term_count <= '0;
            lat_count  <= LAT_LOAD;
        end else if (shift_en) begin
            term_count <= term_count + CNT_W'(1);
        end else if ((state == DRAIN) && (lat_count != '0)) begin
            lat_count  <= lat_count - LAT_W'(1);
        end
    end

    // Result capture, result handshake and completed-window counting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_window_count <= '0;
        end else if (i_abort) begin
            o_result_valid <= 1'b0;
        end else if (capture) begin
            o_result       <= i_sum;
            o_result_valid <= 1'b1;
        end else if (handshake) begin
            o_result_valid <= 1'b0;
            o_window_count <= o_window_count + WINDOW_CNT_W'(1);
        end
    end

    term_window_sreg #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (NUM_TERMS)
    ) u_sreg_a (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .en     (shift_en),
        .din    (i_a),
        .window (o_terms_a)
    );

    term_window_sreg #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (NUM_TERMS)
    ) u_sreg_b (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .en     (shift_en),
        .din    (i_b),
        .window (o_terms_b)
    );

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer with a behavioural multiply/tree-add
// datapath attached to the term buses.
module tb_conv_mac_sequencer;

    localparam int W = 8;
    localparam int N = 72;
    localparam int L = 8;
    localparam int STAGES = L - 1;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic [W-1:0]     i_a;
    logic [W-1:0]     i_b;
    logic             o_ready;
    logic             i_abort;
    logic [N*W-1:0]   o_terms_a;
    logic [N*W-1:0]   o_terms_b;
    logic [W-1:0]     i_sum;
    logic [W-1:0]     o_result;
    logic             o_result_valid;
    logic             i_result_ready;
    logic             o_busy;
    logic [15:0]      o_window_count;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    int last_accept_cyc = 0;

    conv_mac_sequencer #(
        .WORD_WIDTH (W),
        .NUM_TERMS  (N),
        .PIPE_LAT   (L)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .i_a            (i_a),
        .i_b            (i_b),
        .o_ready        (o_ready),
        .i_abort        (i_abort),
        .o_terms_a      (o_terms_a),
        .o_terms_b      (o_terms_b),
        .i_sum          (i_sum),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_busy         (o_busy),
        .o_window_count (o_window_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Behavioural datapath: truncated sum of products, PIPE_LAT-1 register stages
    // so a sum is ready to be sampled PIPE_LAT edges after the bus update.
    logic [W-1:0]   sum_comb;
    logic [2*W-1:0] prod;
    logic [W-1:0]   sum_pipe [STAGES];

    always_comb begin
        sum_comb = '0;
        prod     = '0;
        for (int t = 0; t < N; t++) begin
            prod     = (2*W)'(o_terms_a[t*W +: W]) * (2*W)'(o_terms_b[t*W +: W]);
            sum_comb = sum_comb + prod[W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        sum_pipe[0] <= sum_comb;
        for (int s = 1; s < STAGES; s++) sum_pipe[s] <= sum_pipe[s-1];
    end

    assign i_sum = sum_pipe[STAGES-1];

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time exceeded 1ms, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int waited;
        waited = 0;
        i_valid = 1'b1;
        i_a = a;
        i_b = b;
        while (!o_ready && waited < 200) begin
            @(posedge i_clk); #1;
            waited++;
        end
        if (!o_ready) begin
            assertions++;
            failures++;
            $display("[TB] FAIL send_timeout: o_ready=%0b, required 1", o_ready);
        end else begin
            @(posedge i_clk); #1;
            last_accept_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic feed_const(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
        for (int k = 0; k < n; k++) send_pair(a, b);
        i_valid = 1'b0;
    endtask

    task automatic wait_result(output bit ok, output int lat);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_result_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge i_clk); #1;
        end
        lat = cyc - last_accept_cyc;
    endtask

    task automatic test_reset();
        #3;
        assertions++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_result_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: ready=%0b busy=%0b valid=%0b, required 1 0 0",
                     o_ready, o_busy, o_result_valid);
        end
        assertions++;
        if (o_terms_a !== '0 || o_terms_b !== '0) begin
            failures++;
            $display("[TB] FAIL reset_terms: word0 a=%0d b=%0d, required all zero",
                     o_terms_a[W-1:0], o_terms_b[W-1:0]);
        end
        assertions++;
        if (o_result !== 8'd0 || o_window_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_result: result=%0d count=%0d, required 0 0",
                     o_result, o_window_count);
        end
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        assertions++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_result_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_flags: ready=%0b busy=%0b valid=%0b, required 1 0 0",
                     o_ready, o_busy, o_result_valid);
        end
    endtask

    task automatic test_unit_window();
        bit ok;
        int lat;
        i_result_ready = 1'b1;
        feed_const(8'd1, 8'd1, N);
        assertions++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL unit_drain_entry: busy=%0b ready=%0b, required 1 0", o_busy, o_ready);
        end
        wait_result(ok, lat);
        assertions++;
        if (!ok || lat != L) begin
            failures++;
            $display("[TB] FAIL unit_latency: valid=%0b latency=%0d, required 1 %0d", ok, lat, L);
        end
        assertions++;
        if (o_result !== 8'd72) begin
            failures++;
            $display("[TB] FAIL unit_sum: result=%0d, required 72", o_result);
        end
        @(posedge i_clk); #1;
        assertions++;
        if (o_result_valid !== 1'b0 || o_window_count !== 16'd1 || o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL unit_handshake: valid=%0b count=%0d ready=%0b, required 0 1 1",
                     o_result_valid, o_window_count, o_ready);
        end
    endtask

    task automatic test_truncation();
        bit ok;
        int lat;
        i_result_ready = 1'b1;
        feed_const(8'd2, 8'd3, N);
        wait_result(ok, lat);
        assertions++;
        if (!ok || lat != L || o_result !== 8'd176) begin
            failures++;
            $display("[TB] FAIL trunc_sum: valid=%0b latency=%0d result=%0d, required 1 %0d 176",
                     ok, lat, o_result, L);
        end
        @(posedge i_clk); #1;
        assertions++;
        if (o_window_count !== 16'd2) begin
            failures++;
            $display("[TB] FAIL trunc_count: count=%0d, required 2", o_window_count);
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        int lat;
        i_result_ready = 1'b0;
        feed_const(8'd3, 8'd1, N);
        wait_result(ok, lat);
        assertions++;
        if (!ok || o_result !== 8'd216) begin
            failures++;
            $display("[TB] FAIL bp_sum: valid=%0b result=%0d, required 1 216", ok, o_result);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk); #1;
            assertions++;
            if (o_result_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 8'd216) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d]: valid=%0b ready=%0b result=%0d, required 1 0 216",
                         i, o_result_valid, o_ready, o_result);
            end
        end
        i_result_ready = 1'b1;
        assertions++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_no_bypass: ready=%0b, required 0", o_ready);
        end
        @(posedge i_clk); #1;
        assertions++;
        if (o_result_valid !== 1'b0 || o_ready !== 1'b1 || o_window_count !== 16'd3) begin
            failures++;
            $display("[TB] FAIL bp_release: valid=%0b ready=%0b count=%0d, required 0 1 3",
                     o_result_valid, o_ready, o_window_count);
        end
    endtask

    task automatic test_stall_gaps();
        bit ok;
        int lat;
        i_result_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            send_pair(8'(k % 4), 8'd1);
        end
        i_valid = 1'b0;
        wait_result(ok, lat);
        assertions++;
        if (!ok || lat != L || o_result !== 8'd108) begin
            failures++;
            $display("[TB] FAIL stall_sum: valid=%0b latency=%0d result=%0d, required 1 %0d 108",
                     ok, lat, o_result, L);
        end
        assertions++;
        if (o_terms_a[W-1:0] !== 8'd0 || o_terms_a[N*W-1 -: W] !== 8'd3 || o_terms_a[W +: W] !== 8'd1) begin
            failures++;
            $display("[TB] FAIL stall_order: word0=%0d word1=%0d top=%0d, required 0 1 3",
                     o_terms_a[W-1:0], o_terms_a[W +: W], o_terms_a[N*W-1 -: W]);
        end
        @(posedge i_clk); #1;
        assertions++;
        if (o_window_count !== 16'd4) begin
            failures++;
            $display("[TB] FAIL stall_count: count=%0d, required 4", o_window_count);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int lat;
        i_result_ready = 1'b0;
        for (int k = 0; k < 40; k++) send_pair(8'd5, 8'd5);
        i_abort = 1'b1;
        i_valid = 1'b1;
        i_a = 8'd7;
        i_b = 8'd7;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        i_valid = 1'b0;
        assertions++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_collect: ready=%0b busy=%0b, required 1 0", o_ready, o_busy);
        end
        feed_const(8'd1, 8'd2, N - 1);
        assertions++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_count_clear: busy=%0b after %0d pairs, required 0", o_busy, N - 1);
        end
        feed_const(8'd1, 8'd2, 1);
        assertions++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_window_end: busy=%0b, required 1", o_busy);
        end
        wait_result(ok, lat);
        assertions++;
        if (!ok || lat != L || o_result !== 8'd144) begin
            failures++;
            $display("[TB] FAIL abort_sum: valid=%0b latency=%0d result=%0d, required 1 %0d 144",
                     ok, lat, o_result, L);
        end
        i_abort = 1'b1;
        i_result_ready = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        assertions++;
        if (o_result_valid !== 1'b0 || o_window_count !== 16'd4 || o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_hold: valid=%0b count=%0d ready=%0b, required 0 4 1",
                     o_result_valid, o_window_count, o_ready);
        end
        idle(3);
        assertions++;
        if (o_result_valid !== 1'b0 || o_window_count !== 16'd4) begin
            failures++;
            $display("[TB] FAIL abort_discard: valid=%0b count=%0d, required 0 4",
                     o_result_valid, o_window_count);
        end
    endtask

    task automatic test_reset_mid_window();
        bit ok;
        int lat;
        i_result_ready = 1'b1;
        for (int k = 0; k < 30; k++) send_pair(8'd9, 8'd9);
        i_rst_n = 1'b0;
        #2;
        assertions++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_result_valid !== 1'b0 ||
            o_result !== 8'd0 || o_window_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midrst_outputs: ready=%0b busy=%0b valid=%0b result=%0d count=%0d, required 1 0 0 0 0",
                     o_ready, o_busy, o_result_valid, o_result, o_window_count);
        end
        assertions++;
        if (o_terms_a !== '0 || o_terms_b !== '0) begin
            failures++;
            $display("[TB] FAIL midrst_terms: top a=%0d b=%0d, required all zero",
                     o_terms_a[N*W-1 -: W], o_terms_b[N*W-1 -: W]);
        end
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        feed_const(8'd2, 8'd2, N);
        wait_result(ok, lat);
        assertions++;
        if (!ok || lat != L || o_result !== 8'd32) begin
            failures++;
            $display("[TB] FAIL midrst_sum: valid=%0b latency=%0d result=%0d, required 1 %0d 32",
                     ok, lat, o_result, L);
        end
        @(posedge i_clk); #1;
        assertions++;
        if (o_window_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL midrst_count: count=%0d, required 1", o_window_count);
        end
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_valid        = 1'b0;
        i_a            = '0;
        i_b            = '0;
        i_abort        = 1'b0;
        i_result_ready = 1'b1;

        test_reset();
        test_unit_window();
        test_truncation();
        test_back_pressure();
        test_stall_gaps();
        test_abort();
        test_reset_mid_window();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
